uart_cmd_decoder: RTL and testbench
===================================

# uart_cmd_decoder

Keyboard command decoder between the UART receiver and the Game of Life board controller. It consumes received bytes over a valid/ready handshake, recognises single-key commands and, optionally, ANSI cursor-key escape sequences. It maintains a wrap-around edit cursor and presents one decoded command at a time to the board controller over a valid/ready handshake.

## Interface
Parameters:
- LOG_W, 3, log2 of board width; cursor_x width
- LOG_H, 3, log2 of board height; cursor_y width
- ESC_TIMEOUT, 24000, cycles allowed between bytes of an escape sequence (1 ms at 24 MHz)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high. Ports are named `clk` and `reset`, as elsewhere in the codebase.
- clk  in  1  system clock (24 MHz)
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data is valid
- rx_error  in  1  framing error flag qualifying rx_data
- rx_ready  out  1  decoder can accept a byte
- cmd_valid  out  1  decoded command pending
- cmd_code  out  3  command code (codes listed under Operation)
- cmd_ready  in  1  board controller accepts the command
- cursor_x  out  LOG_W  edit cursor column
- cursor_y  out  LOG_H  edit cursor row

## Operation
- Byte transfer occurs when rx_valid & rx_ready; command transfer occurs when cmd_valid & cmd_ready.
- rx_ready = ~cmd_valid & ~reset. There is a one-deep command buffer, and no byte is consumed while a command is pending.
- Command codes (unsigned, 3 bits):
  - 1 RANDOMIZE ('0', 0x30)
  - 2 STEP ('1', 0x31)
  - 3 RUN_TOGGLE (' ', 0x20)
  - 4 CURSOR_MOVED
  - 5 CELL_TOGGLE ('x'/'X')
  - 6 CLEAR ('c'/'C')
  - 0 is never emitted.
- Cursor keys (lower and upper case): 'w' moves y-1, 's' y+1, 'a' x-1, 'd' x+1.
  - Arithmetic is modulo 2^LOG_W / 2^LOG_H: x=7 plus 1 gives 0; y=0 minus 1 gives 7.
  - Each cursor key updates the cursor and emits CURSOR_MOVED.
- An accepted byte with rx_error=1 is discarded, emits nothing, and returns the parser to IDLE.
- Unknown bytes are discarded silently.
- Parser states: IDLE, ESC, CSI. Only IDLE exists without the macro.
  - IDLE, 0x1B: go to ESC.
  - ESC, '[' (0x5B): go to CSI.
  - ESC, any other byte: go to IDLE, and the byte is decoded as an IDLE byte in the same cycle.
  - CSI, byte 0x20–0x3F: parameter or intermediate byte; ignored, stay in CSI. After the 8th such byte, abort to IDLE.
  - CSI, byte 0x40–0x7E: final byte. 'A' is up, 'B' down, 'C' right, 'D' left, each behaving as w/s/d/a. Any other final byte is dropped. Go to IDLE.
  - CSI, any other byte: abort to IDLE, byte dropped.
  - Timeout: in ESC or CSI, the counter clears on each accepted byte. When it reaches ESC_TIMEOUT-1, the parser goes to IDLE with nothing emitted.

## Timing
- Reset values: cmd_valid=0, cmd_code=0, cursor_x=0, cursor_y=0, parser IDLE, timeout counter 0, rx_ready=0 while reset is asserted.
- Byte accepted in cycle N: cmd_valid, cmd_code and the cursor update appear at N+1. Latency is 1 cycle.
- cmd_valid and cmd_code are held stable until a transfer. If the transfer happens in cycle M, cmd_valid=0 and rx_ready=1 in cycle M+1.
- Maximum throughput is one command per 2 cycles when cmd_ready is tied high.
- Timeout counter width is $clog2(ESC_TIMEOUT). Timeout is checked only while no byte is being accepted. If a byte arrives in the timeout cycle, the byte wins.
- Reset asserted mid-sequence or with a command pending clears everything, and the pending command is lost.

## Configuration
- Macro: CMD_ANSI_EN.
- Defined: ESC and CSI parsing, the timeout counter, and arrow keys are active.
- Undefined: 0x1B is an unknown byte and is dropped; 'w'/'a'/'s'/'d' still move the cursor; no timeout logic is synthesised.

## Structure
- Package uart_cmd_pkg holds:
  - command code constants (CMD_RANDOMIZE … CMD_CLEAR) shared with the board controller
  - ASCII constants (ESC, '[', key codes)
  - the parser state enum
- Sub-module cmd_esc_parser (ESC/CSI FSM plus timeout counter) reports a decoded direction or a pass-through byte. It is instantiated only under CMD_ANSI_EN.

## Test plan
- After reset with cmd_ready=1, send 0x31: cmd_code=2 for exactly one cycle at N+1. Send 0x20: cmd_code=3.
- With cursor at (7,0), send 'd' then 'w': cursor becomes (0,0) then (0,7), with two CURSOR_MOVED commands.
- Hold cmd_ready=0 and send '0' then '1': rx_ready stays 0 after the first byte and cmd_code=1 holds. Raise cmd_ready: the second byte is then accepted and cmd_code=2 follows.
- With CMD_ANSI_EN, send 1B 5B 41 spaced by 100 cycles: one CURSOR_MOVED, y decremented. Send 1B 5B 31 3B 32 43: x incremented.
- With CMD_ANSI_EN, send 1B and wait ESC_TIMEOUT cycles, then 'x': no command for the ESC, then CELL_TOGGLE. Send 1B then 'c': CLEAR.
- Send 0x31 with rx_error=1: no command. Assert reset mid-CSI with a command pending: all outputs return to their reset values.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART keyboard command decoder: command codes, ASCII keys, parser state.
// Command codes are also consumed by the board controller.
package uart_cmd_pkg;

   localparam logic [2:0] CMD_NONE         = 3'd0;
   localparam logic [2:0] CMD_RANDOMIZE    = 3'd1;
   localparam logic [2:0] CMD_STEP         = 3'd2;
   localparam logic [2:0] CMD_RUN_TOGGLE   = 3'd3;
   localparam logic [2:0] CMD_CURSOR_MOVED = 3'd4;
   localparam logic [2:0] CMD_CELL_TOGGLE  = 3'd5;
   localparam logic [2:0] CMD_CLEAR        = 3'd6;

   localparam logic [7:0] ASCII_ESC      = 8'h1B;
   localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
   localparam logic [7:0] KEY_RANDOMIZE  = 8'h30;
   localparam logic [7:0] KEY_STEP       = 8'h31;
   localparam logic [7:0] KEY_RUN        = 8'h20;
   localparam logic [7:0] KEY_X_LO       = 8'h78;
   localparam logic [7:0] KEY_X_UP       = 8'h58;
   localparam logic [7:0] KEY_C_LO       = 8'h63;
   localparam logic [7:0] KEY_C_UP       = 8'h43;
   localparam logic [7:0] KEY_W_LO       = 8'h77;
   localparam logic [7:0] KEY_W_UP       = 8'h57;
   localparam logic [7:0] KEY_S_LO       = 8'h73;
   localparam logic [7:0] KEY_S_UP       = 8'h53;
   localparam logic [7:0] KEY_A_LO       = 8'h61;
   localparam logic [7:0] KEY_A_UP       = 8'h41;
   localparam logic [7:0] KEY_D_LO       = 8'h64;
   localparam logic [7:0] KEY_D_UP       = 8'h44;
   localparam logic [7:0] CSI_UP         = 8'h41;
   localparam logic [7:0] CSI_DOWN       = 8'h42;
   localparam logic [7:0] CSI_RIGHT      = 8'h43;
   localparam logic [7:0] CSI_LEFT       = 8'h44;

   typedef enum logic [1:0] {StIdle, StEsc, StCsi} parse_state_e;

   typedef enum logic [2:0] {DirNone, DirUp, DirDown, DirLeft, DirRight} dir_e;

endpackage

// File: rtl/cmd_esc_parser.sv
// ESC / CSI escape-sequence parser with inter-byte timeout. Reports an arrow-key direction or
// flags the accepted byte for plain single-key decoding. Used only when CMD_ANSI_EN is defined.
module cmd_esc_parser
   import uart_cmd_pkg::*;
#(
   parameter int unsigned ESC_TIMEOUT = 24000
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       byte_valid_i,
   input  logic       byte_error_i,
   input  logic [7:0] byte_i,
   output dir_e       dir_o,
   output logic       pass_o
);

   localparam int unsigned CntW = (ESC_TIMEOUT > 1) ? $clog2(ESC_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(ESC_TIMEOUT - 1);

   parse_state_e    state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      par_q, par_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      dir_o   = DirNone;
      pass_o  = 1'b0;
      if (byte_valid_i) begin
         cnt_d = '0;
         if (byte_error_i) begin
            state_d = StIdle;
         end else begin
            case (state_q)
               StIdle: begin
                  if (byte_i == ASCII_ESC) state_d = StEsc;
                  else                     pass_o  = 1'b1;
               end
               StEsc: begin
                  // A non-'[' byte is re-decoded as if it arrived in idle, so ESC ESC re-arms.
                  if (byte_i == ASCII_LBRACKET) begin
                     state_d = StCsi;
                     par_d   = '0;
                  end else if (byte_i == ASCII_ESC) begin
                     state_d = StEsc;
                  end else begin
                     state_d = StIdle;
                     pass_o  = 1'b1;
                  end
               end
               StCsi: begin
                  if (byte_i >= 8'h20 && byte_i <= 8'h3F) begin
                     if (par_q == 3'd7) state_d = StIdle;
                     else               par_d   = par_q + 3'd1;
                  end else begin
                     state_d = StIdle;
                     if (byte_i >= 8'h40 && byte_i <= 8'h7E) begin
                        case (byte_i)
                           CSI_UP:    dir_o = DirUp;
                           CSI_DOWN:  dir_o = DirDown;
                           CSI_RIGHT: dir_o = DirRight;
                           CSI_LEFT:  dir_o = DirLeft;
                           default:   dir_o = DirNone;
                        endcase
                     end
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end else if (state_q != StIdle) begin
         if (cnt_q == CntMax) begin
            state_d = StIdle;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         par_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         par_q   <= par_d;
      end
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Keyboard command decoder: UART bytes in, one-deep buffered board commands out, wrapping cursor.
// Define CMD_ANSI_EN to add ANSI arrow-key escape parsing with an inter-byte timeout.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int unsigned LOG_W       = 3,
   parameter int unsigned LOG_H       = 3,
   parameter int unsigned ESC_TIMEOUT = 24000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_error,
   output logic             rx_ready,
   output logic             cmd_valid,
   output logic [2:0]       cmd_code,
   input  logic             cmd_ready,
   output logic [LOG_W-1:0] cursor_x,
   output logic [LOG_H-1:0] cursor_y
);

   logic             cmd_valid_q, cmd_valid_d;
   logic [2:0]       cmd_code_q, cmd_code_d;
   logic [LOG_W-1:0] cursor_x_q, cursor_x_d;
   logic [LOG_H-1:0] cursor_y_q, cursor_y_d;
   logic             accept;
   logic             pass_valid;
   dir_e             esc_dir;
   dir_e             key_dir;
   logic [2:0]       emit;

   assign rx_ready = ~cmd_valid_q & ~reset;
   assign accept   = rx_valid & rx_ready;

`ifdef CMD_ANSI_EN
   cmd_esc_parser #(
      .ESC_TIMEOUT(ESC_TIMEOUT)
   ) u_esc_parser (
      .clk_i       (clk),
      .reset_i     (reset),
      .byte_valid_i(accept),
      .byte_error_i(rx_error),
      .byte_i      (rx_data),
      .dir_o       (esc_dir),
      .pass_o      (pass_valid)
   );
`else
   assign esc_dir    = DirNone;
   assign pass_valid = accept & ~rx_error;
`endif

   always_comb begin
      cmd_valid_d = cmd_valid_q;
      cmd_code_d  = cmd_code_q;
      cursor_x_d  = cursor_x_q;
      cursor_y_d  = cursor_y_q;
      key_dir     = esc_dir;
      emit        = CMD_NONE;
      if (pass_valid) begin
         case (rx_data)
            KEY_RANDOMIZE:      emit    = CMD_RANDOMIZE;
            KEY_STEP:           emit    = CMD_STEP;
            KEY_RUN:            emit    = CMD_RUN_TOGGLE;
            KEY_X_LO, KEY_X_UP: emit    = CMD_CELL_TOGGLE;
            KEY_C_LO, KEY_C_UP: emit    = CMD_CLEAR;
            KEY_W_LO, KEY_W_UP: key_dir = DirUp;
            KEY_S_LO, KEY_S_UP: key_dir = DirDown;
            KEY_A_LO, KEY_A_UP: key_dir = DirLeft;
            KEY_D_LO, KEY_D_UP: key_dir = DirRight;
            default:            emit    = CMD_NONE;
         endcase
      end
      // Cursor arithmetic wraps naturally at the register width.
      case (key_dir)
         DirUp:    cursor_y_d = cursor_y_q - LOG_H'(1);
         DirDown:  cursor_y_d = cursor_y_q + LOG_H'(1);
         DirLeft:  cursor_x_d = cursor_x_q - LOG_W'(1);
         DirRight: cursor_x_d = cursor_x_q + LOG_W'(1);
         default:  ;
      endcase
      if (key_dir != DirNone) emit = CMD_CURSOR_MOVED;
      if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;
      if (emit != CMD_NONE) begin
         cmd_valid_d = 1'b1;
         cmd_code_d  = emit;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= CMD_NONE;
         cursor_x_q  <= '0;
         cursor_y_q  <= '0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         cursor_x_q  <= cursor_x_d;
         cursor_y_q  <= cursor_y_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign cursor_x  = cursor_x_q;
   assign cursor_y  = cursor_y_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder; escape-sequence cases run when CMD_ANSI_EN
// is defined.
module tb_uart_cmd_decoder;

   localparam int unsigned TIMEOUT = 24000;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic       rx_ready;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic       cmd_ready;
   logic [2:0] cursor_x;
   logic [2:0] cursor_y;

   int n_checks = 0;
   int n_fail   = 0;

   uart_cmd_decoder #(
      .LOG_W      (3),
      .LOG_H      (3),
      .ESC_TIMEOUT(TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_error (rx_error),
      .rx_ready (rx_ready),
      .cmd_valid(cmd_valid),
      .cmd_code (cmd_code),
      .cmd_ready(cmd_ready),
      .cursor_x (cursor_x),
      .cursor_y (cursor_y)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one byte until accepted; returns 1 ns after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input logic err);
      int n = 0;
      rx_data  = b;
      rx_error = err;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) check_eq("rx_ready_wait", 0, 1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic expect_cmd(input string tag, input int unsigned code);
      check_eq({tag, "_valid"}, cmd_valid, 1);
      check_eq({tag, "_code"}, cmd_code, code);
   endtask

   task automatic expect_cursor(input string tag, input int unsigned x, input int unsigned y);
      check_eq({tag, "_x"}, cursor_x, x);
      check_eq({tag, "_y"}, cursor_y, y);
   endtask

   initial begin
      reset     = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      rx_error  = 1'b0;
      cmd_ready = 1'b1;
      step(3);
      check_eq("rst_rx_ready", rx_ready, 0);
      check_eq("rst_cmd_valid", cmd_valid, 0);
      check_eq("rst_cmd_code", cmd_code, 0);
      expect_cursor("rst_cursor", 0, 0);
      reset = 1'b0;
      step(1);
      check_eq("post_rst_rx_ready", rx_ready, 1);

      // Single keys, one-cycle command pulse with cmd_ready high
      send_byte(8'h31, 1'b0);
      expect_cmd("step", 2);
      step(1);
      check_eq("step_drop_valid", cmd_valid, 0);
      check_eq("step_rx_ready", rx_ready, 1);
      send_byte(8'h20, 1'b0);
      expect_cmd("run", 3);
      send_byte("X", 1'b0);
      expect_cmd("cell_up", 5);
      send_byte("c", 1'b0);
      expect_cmd("clear_lo", 6);

      // Cursor wrap-around
      send_byte("a", 1'b0);
      expect_cmd("left_wrap", 4);
      expect_cursor("left_wrap", 7, 0);
      send_byte("d", 1'b0);
      expect_cmd("right_wrap", 4);
      expect_cursor("right_wrap", 0, 0);
      send_byte("w", 1'b0);
      expect_cmd("up_wrap", 4);
      expect_cursor("up_wrap", 0, 7);
      send_byte("S", 1'b0);
      expect_cursor("down_wrap", 0, 0);

      // Back-pressure: one-deep buffer holds, second byte waits
      step(1);
      cmd_ready = 1'b0;
      send_byte(8'h30, 1'b0);
      expect_cmd("bp_first", 1);
      rx_data  = 8'h31;
      rx_valid = 1'b1;
      step(3);
      check_eq("bp_rx_ready", rx_ready, 0);
      expect_cmd("bp_hold", 1);
      cmd_ready = 1'b1;
      step(1);
      check_eq("bp_xfer_valid", cmd_valid, 0);
      check_eq("bp_xfer_ready", rx_ready, 1);
      step(1);
      rx_valid = 1'b0;
      expect_cmd("bp_second", 2);

      // Framing error and unknown bytes emit nothing
      send_byte(8'h31, 1'b1);
      check_eq("rx_error_drop", cmd_valid, 0);
      step(2);
      check_eq("rx_error_later", cmd_valid, 0);
      send_byte("q", 1'b0);
      check_eq("unknown_drop", cmd_valid, 0);
      // ESC followed by a plain key decodes the key in both builds
      send_byte(8'h1B, 1'b0);
      check_eq("esc_no_cmd", cmd_valid, 0);
      send_byte("c", 1'b0);
      expect_cmd("esc_then_clear", 6);
      step(1);

`ifdef CMD_ANSI_EN
      send_byte(8'h1B, 1'b0);
      step(100);
      send_byte(8'h5B, 1'b0);
      step(100);
      check_eq("csi_up_quiet", cmd_valid, 0);
      send_byte(8'h41, 1'b0);
      expect_cmd("csi_up", 4);
      expect_cursor("csi_up", 0, 7);
      step(1);
      check_eq("csi_up_once", cmd_valid, 0);
      send_byte(8'h1B, 1'b0);
      send_byte(8'h5B, 1'b0);
      send_byte(8'h31, 1'b0);
      send_byte(8'h3B, 1'b0);
      send_byte(8'h32, 1'b0);
      check_eq("csi_param_quiet", cmd_valid, 0);
      send_byte(8'h43, 1'b0);
      expect_cmd("csi_right", 4);
      expect_cursor("csi_right", 1, 7);

      // Timeout in CSI: following 'x' is a plain key rather than a dropped final byte
      send_byte(8'h1B, 1'b0);
      send_byte(8'h5B, 1'b0);
      step(TIMEOUT + 5);
      check_eq("csi_timeout_quiet", cmd_valid, 0);
      send_byte("x", 1'b0);
      expect_cmd("after_csi_timeout", 5);
      send_byte(8'h1B, 1'b0);
      step(TIMEOUT + 5);
      send_byte("x", 1'b0);
      expect_cmd("after_esc_timeout", 5);

      // Eight parameter bytes abort; seven do not
      send_byte(8'h1B, 1'b0);
      send_byte(8'h5B, 1'b0);
      for (int i = 0; i < 8; i++) send_byte(8'h31, 1'b0);
      send_byte("x", 1'b0);
      expect_cmd("csi_abort_8", 5);
      send_byte(8'h1B, 1'b0);
      send_byte(8'h5B, 1'b0);
      for (int i = 0; i < 7; i++) send_byte(8'h31, 1'b0);
      send_byte(8'h42, 1'b0);
      expect_cmd("csi_7_params", 4);
      expect_cursor("csi_7_params", 1, 0);

      // Reset inside CSI returns parser to idle: 'A' then acts as a left key
      send_byte(8'h1B, 1'b0);
      send_byte(8'h5B, 1'b0);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
      send_byte(8'h41, 1'b0);
      expect_cmd("csi_reset_idle", 4);
      expect_cursor("csi_reset_idle", 7, 0);
      step(1);
`endif

      // Reset with a command pending clears everything
      cmd_ready = 1'b0;
      send_byte("s", 1'b0);
      expect_cmd("pending", 4);
      reset = 1'b1;
      #2;
      check_eq("mid_rst_valid", cmd_valid, 0);
      check_eq("mid_rst_code", cmd_code, 0);
      check_eq("mid_rst_rx_ready", rx_ready, 0);
      expect_cursor("mid_rst", 0, 0);
      step(1);
      reset     = 1'b0;
      cmd_ready = 1'b1;
      step(2);
      check_eq("mid_rst_after_valid", cmd_valid, 0);
      check_eq("mid_rst_after_ready", rx_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
